// File: rtl/team_06_i2c_pkg.sv
// Shared types and constants for the I2C write-only master.
package team_06_i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    STOP
  } i2c_state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic I2C_WRITE_BIT = 1'b0;

  // First byte on the wire: 7-bit address followed by the R/W bit.
  function automatic logic [7:0] addr_byte(input logic [6:0] addr);
    return {addr, I2C_WRITE_BIT};
  endfunction

endpackage

// File: rtl/team_06_i2c_master_tx_if.sv
// Request/status and pad-level signals between control logic, the master and the bus pads.
interface team_06_i2c_master_tx_if #(
  parameter int unsigned MAX_BYTES = 4,
  parameter int unsigned CW        = $clog2(MAX_BYTES + 1)
);

  logic                     start;
  logic [6:0]               dev_addr;
  logic [8*MAX_BYTES-1:0]   payload;
  logic [CW-1:0]            nbytes;
  logic                     sda_in;
  logic                     scl_in;
  logic                     sda_oe;
  logic                     scl_oe;
  logic                     busy;
  logic                     done;
  logic                     nack;

  modport master (
    input  start, dev_addr, payload, nbytes, sda_in, scl_in,
    output sda_oe, scl_oe, busy, done, nack
  );

  modport slave (
    output start, dev_addr, payload, nbytes, sda_in, scl_in,
    input  sda_oe, scl_oe, busy, done, nack
  );

endinterface

// File: rtl/team_06_i2c_qtick.sv
// Quarter-SCL-period timer: counts QDIV clocks per quarter, freezes while hold is high.
module team_06_i2c_qtick
  import team_06_i2c_pkg::*;
#(
  parameter int unsigned QDIV = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       hold,
  output logic       tick,
  output logic [1:0] qidx
);

  localparam int unsigned CNT_W = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(QDIV - 1);

  logic [CNT_W-1:0] cnt;

  // tick is kept equal to (cnt == LAST) so it is available as a flop output.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt  <= '0;
      qidx <= Q0;
      tick <= 1'b0;
    end else if (!hold) begin
      if (tick) begin
        cnt  <= '0;
        qidx <= qidx + 2'd1;
        tick <= 1'b0;
      end else begin
        cnt  <= cnt + CNT_W'(1);
        tick <= ((cnt + CNT_W'(1)) == LAST);
      end
    end
  end

endmodule

// File: rtl/team_06_i2c_master_tx.sv
// I2C write-only master: START, address+W, up to MAX_BYTES data bytes with ACK checks, STOP.
module team_06_i2c_master_tx
  import team_06_i2c_pkg::*;
#(
  parameter int unsigned QDIV      = 125,
  parameter int unsigned MAX_BYTES = 4,
  parameter int unsigned CW        = $clog2(MAX_BYTES + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  team_06_i2c_master_tx_if.master      bus
);

  i2c_state_t                 state;
  logic [6:0]                 addr_q;
  logic [MAX_BYTES-1:0][7:0]  payload_q;
  logic [CW-1:0]              count;
  logic [CW-1:0]              byte_idx;
  logic [CW-1:0]              byte_next;
  logic [2:0]                 bit_cnt;
  logic [7:0]                 shreg;
  logic [7:0]                 abyte;
  logic [7:0]                 nxt_byte;
  logic                       ack_smp;
  logic                       tick;
  logic                       hold;
  logic                       step;
  logic [1:0]                 qidx;

  assign abyte     = addr_byte(addr_q);
  assign byte_next = byte_idx + CW'(1);
  // Slave stretches by holding SCL low after we released it in the high half of a bit.
  assign hold      = qidx[1] && !bus.scl_oe && !bus.scl_in;
  assign step      = tick && !hold;

  team_06_i2c_qtick #(.QDIV(QDIV)) u_qtick (
    .clk  (clk),
    .rst  (rst),
    .en   (state != IDLE),
    .hold (hold),
    .tick (tick),
    .qidx (qidx)
  );

  always_comb begin
    nxt_byte = 8'h00;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (byte_next == CW'(i)) nxt_byte = payload_q[i];
    end
  end

  // Outputs are updated on the same edge as qidx so they always match the current quarter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bus.sda_oe <= 1'b0;
      bus.scl_oe <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.nack   <= 1'b0;
      addr_q     <= '0;
      payload_q  <= '0;
      count      <= '0;
      byte_idx   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      ack_smp    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (state == IDLE) begin
        bus.sda_oe <= 1'b0;
        bus.scl_oe <= 1'b0;
        if (bus.start) begin
          state     <= START;
          bus.busy  <= 1'b1;
          bus.nack  <= 1'b0;
          addr_q    <= bus.dev_addr;
          payload_q <= bus.payload;
          count     <= (bus.nbytes > CW'(MAX_BYTES)) ? CW'(MAX_BYTES) : bus.nbytes;
          byte_idx  <= '0;
        end
      end else if (step) begin
        case (qidx)
          Q1: begin
            bus.scl_oe <= 1'b0;
            if (state == START) bus.sda_oe <= 1'b1;
          end
          Q2: begin
            if (state == STOP) bus.sda_oe <= 1'b0;
            if (state == ADDR_ACK || state == DATA_ACK) ack_smp <= bus.sda_in;
          end
          Q3: begin
            bus.scl_oe <= 1'b1;
            case (state)
              START: begin
                state      <= ADDR;
                bit_cnt    <= '0;
                bus.sda_oe <= ~abyte[7];
                shreg      <= {abyte[6:0], 1'b0};
              end
              ADDR, DATA: begin
                if (bit_cnt == 3'd7) begin
                  state      <= (state == ADDR) ? ADDR_ACK : DATA_ACK;
                  bus.sda_oe <= 1'b0;
                end else begin
                  bit_cnt    <= bit_cnt + 3'd1;
                  bus.sda_oe <= ~shreg[7];
                  shreg      <= {shreg[6:0], 1'b0};
                end
              end
              ADDR_ACK: begin
                if (ack_smp || count == '0) begin
                  bus.nack   <= ack_smp;
                  state      <= STOP;
                  bus.sda_oe <= 1'b1;
                end else begin
                  state      <= DATA;
                  bit_cnt    <= '0;
                  bus.sda_oe <= ~payload_q[0][7];
                  shreg      <= {payload_q[0][6:0], 1'b0};
                end
              end
              DATA_ACK: begin
                if (ack_smp || byte_next == count) begin
                  bus.nack   <= ack_smp;
                  state      <= STOP;
                  bus.sda_oe <= 1'b1;
                end else begin
                  byte_idx   <= byte_next;
                  state      <= DATA;
                  bit_cnt    <= '0;
                  bus.sda_oe <= ~nxt_byte[7];
                  shreg      <= {nxt_byte[6:0], 1'b0};
                end
              end
              STOP: begin
                state      <= IDLE;
                bus.scl_oe <= 1'b0;
                bus.sda_oe <= 1'b0;
                bus.busy   <= 1'b0;
                bus.done   <= 1'b1;
              end
              default: state <= IDLE;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_team_06_i2c_master_tx.sv
// Directed bench: bus decoder with ACK-responding slave, scoreboard of expected bus events.
module tb_team_06_i2c_master_tx;

  localparam int unsigned QDIV = 4;
  localparam int unsigned MAX  = 4;
  localparam int unsigned CW   = $clog2(MAX + 1);

  typedef logic [10:0] ev_t;
  localparam ev_t EV_START = 11'h200;
  localparam ev_t EV_STOP  = 11'h600;
  localparam ev_t EV_NONE  = 11'h7FF;

  logic clk = 1'b0;
  logic rst;
  logic stretch   = 1'b0;
  logic slave_pull = 1'b0;
  logic [4:0] slave_resp = 5'b0;
  bit   sb_ignore = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;
  int fall_cnt = 0;
  ev_t exp_q[$];

  always #5 clk = ~clk;

  team_06_i2c_master_tx_if #(.MAX_BYTES(MAX), .CW(CW)) bus ();

  team_06_i2c_master_tx #(.QDIV(QDIV), .MAX_BYTES(MAX), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic scl_w, sda_w;
  assign scl_w = !bus.scl_oe && !stretch;
  assign sda_w = !bus.sda_oe && !slave_pull;
  assign bus.scl_in = scl_w;
  assign bus.sda_in = sda_w;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input ev_t ev);
    ev_t e;
    if (sb_ignore) return;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : EV_NONE;
    check("bus_event", 32'(ev), 32'(e));
  endtask

  // Bus decoder and slave: START/STOP detection, 9-bit frames, ACK drive in the 9th slot.
  initial begin
    logic scl_p, sda_p;
    logic [8:0] sh;
    logic [4:0] rs;
    int nb, frame;
    scl_p = 1'b1; sda_p = 1'b1; sh = '0; nb = 0; frame = 0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        if (scl_p && scl_w && sda_p && !sda_w) begin
          sb_check(EV_START);
          nb = 0; frame = 0; fall_cnt = 0; slave_pull = 1'b0;
        end else if (scl_p && scl_w && !sda_p && sda_w) begin
          sb_check(EV_STOP);
          nb = 0;
        end else if (!scl_p && scl_w) begin
          sh = {sh[7:0], sda_w};
          nb++;
          if (nb == 9) begin
            sb_check({2'b10, sh});
            nb = 0;
            frame++;
          end
        end else if (scl_p && !scl_w) begin
          fall_cnt++;
          rs = slave_resp >> frame;
          slave_pull = (nb == 8) ? !rs[0] : 1'b0;
        end
      end
      scl_p = scl_w;
      sda_p = sda_w;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic run_tx(input logic [6:0] a, input logic [31:0] p, input logic [CW-1:0] n,
                        input logic [4:0] r, input bit strch, input bit extra);
    int k, sent, exp_cyc, c, w, gl;
    logic nck, seen, s0;
    logic [31:0] pb;
    logic [4:0] rb;
    sb_ignore = 1'b0;
    k = (int'(n) > MAX) ? MAX : int'(n);
    sent = 0;
    nck = r[0];
    exp_q.push_back(EV_START);
    exp_q.push_back({2'b10, a, 1'b0, r[0]});
    if (!r[0]) begin
      for (int i = 0; i < k; i++) begin
        pb = p >> (8 * i);
        rb = r >> (i + 1);
        exp_q.push_back({2'b10, pb[7:0], rb[0]});
        sent++;
        if (rb[0]) begin
          nck = 1'b1;
          break;
        end
      end
    end
    exp_q.push_back(EV_STOP);
    exp_cyc = 4 * QDIV * (11 + 9 * sent) + (strch ? 20 : 0);

    @(negedge clk);
    bus.dev_addr = a; bus.payload = p; bus.nbytes = n; slave_resp = r; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1'b1);
    check("nack_cleared", bus.nack, 1'b0);

    c = 0; seen = 1'b0;
    fork
      begin
        while (!seen && c < exp_cyc + 400) begin
          @(posedge clk);
          c++;
          #1;
          if (extra && c == 50) begin
            bus.start = 1'b1; bus.dev_addr = 7'h7F; bus.nbytes = CW'(1);
          end
          if (extra && c == 51) bus.start = 1'b0;
          if (bus.done === 1'b1) seen = 1'b1;
        end
      end
      begin
        if (strch) begin
          w = 0; gl = 0;
          while (fall_cnt != 3 && w < 2000) begin @(negedge clk); #1; w++; end
          check("stretch_arm", 32'(fall_cnt), 32'd3);
          stretch = 1'b1;
          w = 0;
          while (bus.scl_oe !== 1'b0 && w < 2000) begin @(posedge clk); #1; w++; end
          check("stretch_hit", bus.scl_oe, 1'b0);
          s0 = bus.sda_oe;
          repeat (20) begin
            @(posedge clk); #1;
            if (bus.sda_oe !== s0) gl++;
          end
          stretch = 1'b0;
          check("stretch_sda_stable", 32'(gl), 32'd0);
        end
      end
    join

    check("done_seen", seen, 1'b1);
    if (seen) begin
      check("cycles", 32'(c), 32'(exp_cyc));
      check("nack", bus.nack, nck);
      @(posedge clk); #1;
      check("done_one_cycle", bus.done, 1'b0);
      check("busy_low", bus.busy, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      check("no_requeue", bus.busy, 1'b0);
      check("nack_held", bus.nack, nck);
    end
    check("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int w;
    rst = 1'b1;
    bus.start = 1'b0; bus.dev_addr = '0; bus.payload = '0; bus.nbytes = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sda_oe", bus.sda_oe, 1'b0);
    check("rst_scl_oe", bus.scl_oe, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_nack", bus.nack, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    run_tx(7'h1A, 32'h0000_3CA5, CW'(2), 5'b00000, 1'b0, 1'b0);
    run_tx(7'h1A, 32'h0000_3CA5, CW'(2), 5'b00001, 1'b0, 1'b0);
    run_tx(7'h50, 32'h0033_2211, CW'(3), 5'b00100, 1'b0, 1'b0);
    run_tx(7'h1A, 32'h0000_005A, CW'(1), 5'b00000, 1'b1, 1'b0);

    // Abort a transfer with reset while data bits are on the wire.
    sb_ignore = 1'b1;
    @(negedge clk);
    bus.dev_addr = 7'h33; bus.payload = 32'hF0F0_F0F0; bus.nbytes = CW'(4);
    slave_resp = 5'b0; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    w = 0;
    while (fall_cnt != 12 && w < 3000) begin @(negedge clk); #1; w++; end
    check("reach_data", 32'(fall_cnt), 32'd12);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_sda_oe", bus.sda_oe, 1'b0);
    check("midrst_scl_oe", bus.scl_oe, 1'b0);
    check("midrst_busy", bus.busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    run_tx(7'h2B, 32'hDEAD_BEEF, CW'(4), 5'b00000, 1'b0, 1'b0);

    run_tx(7'h1A, 32'h0000_0000, CW'(0), 5'b00000, 1'b0, 1'b0);
    run_tx(7'h55, 32'h0123_4567, CW'(7), 5'b00000, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/team_06_i2c_master_tx.md
Name: team_06_i2c_master_tx

Overview:
- Parametrised I2C write-only master. Replaces the fixed single-effect prototype.
- Sends START, 7-bit address + W, then 0..MAX_BYTES data bytes with ACK checking, then STOP.
- Sits between the effect/control logic (which loads the payload) and the open-drain SDA/SCL pads (e.g. DAC/codec configuration).
- Adds over the prototype: multi-byte payload, NACK abort, clock stretching, programmable bit rate.

Parameters:
- QDIV, 125, system clocks per quarter SCL period (bit rate = f_clk/(4*QDIV)); legal range 2..4095.
- MAX_BYTES, 4, maximum payload bytes per transaction; legal range 1..16.
- CW, $clog2(MAX_BYTES+1), width of the byte-count port.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- dev_addr  in  7  target address, latched on accepted start
- payload  in  8*MAX_BYTES  byte 0 in [7:0], sent first, MSB first; latched on start
- nbytes  in  CW  bytes to send; latched; values >MAX_BYTES clamp to MAX_BYTES
- sda_in  in  1  synchronised SDA pad level
- scl_in  in  1  synchronised SCL pad level
- sda_oe  out  1  1 = drive SDA low, 0 = release
- scl_oe  out  1  1 = drive SCL low, 0 = release
- busy  out  1  high from accepted start until return to IDLE
- done  out  1  one-cycle pulse at STOP completion
- nack  out  1  valid with done; 1 = transaction aborted on NACK

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: sda_oe=0, scl_oe=0, busy=0, done=0, nack=0, state IDLE, quarter counter 0.
- Reset mid-transaction releases both lines on the next edge; no STOP is generated.
- Quarter tick:
  - Counter runs 0..QDIV-1 while not IDLE; tick asserts when it reaches QDIV-1.
  - Each bit is 4 quarters q0..q3.
  - scl_oe=1 in q0/q1 and 0 in q2/q3.
  - SDA changes only at q0 entry.
  - SDA is sampled at the end of q2.
- Clock stretching: in q2/q3, if scl_oe=0 and scl_in=0, the counter holds. Timing resumes once scl_in=1.
- State machine:
  - IDLE: lines released. On start, latch inputs, busy=1, go to START.
  - START: q0/q1 with SCL released and SDA released; q2/q3 SDA low with SCL released. Exit with SCL driven low.
  - ADDR: 8 bits = {dev_addr, 1'b0}, MSB first.
  - ADDR_ACK: SDA released, sample at q2. If 0, go to DATA (or STOP if nbytes=0); if 1, set nack flag and go to STOP.
  - DATA: 8 bits of payload[byte_idx], MSB first.
  - DATA_ACK: sample as in ADDR_ACK. On ACK, byte_idx+1; if byte_idx+1==count go to STOP, else DATA. On NACK, set nack and go to STOP.
  - STOP: q0/q1 SDA low with SCL low; q2 SCL released with SDA low; q3 SDA released. Then pulse done (with nack) and go to IDLE; busy falls the same cycle.
- start while busy is ignored; no queueing.
- Total SCL bit-slots for n bytes with all ACKs: 1 + 9 + 9n + 1. Clocks = 4*QDIV*(11+9n), no stretch.
- nack stays valid until the next accepted start clears it.
- Arbitration loss is not detected (single-master bus).

Decomposition:
- Package team_06_i2c_pkg:
  - state enum i2c_state_t (IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP)
  - localparams for quarter indices Q0..Q3
  - I2C_WRITE_BIT=1'b0
- One sub-module, team_06_i2c_qtick. Contains the quarter-period counter with hold input (stretch) and enable. Outputs tick and qidx[1:0].
- Bit/byte counters and the FSM stay in the top module.

Test Plan:
- QDIV=4, dev_addr=7'h1A, nbytes=2, payload bytes 8'hA5 then 8'h3C, slave ACKs all -> bus decodes START, 0x34, ACK, 0xA5, ACK, 0x3C, ACK, STOP. done pulses once with nack=0 after exactly 4*4*29 cycles.
- Same request, slave NACKs the address -> no data bits clocked, STOP follows ADDR_ACK, done=1 with nack=1.
- ACK on byte 0, NACK on byte 1 of a 3-byte transfer -> STOP immediately after the byte-1 ACK slot, nack=1, byte 2 never appears.
- Slave holds scl_in low for 20 cycles during the 3rd address bit's high phase -> bit period extends by 20 cycles, data correct, no glitch on sda_oe.
- rst asserted mid-DATA -> next cycle sda_oe=0, scl_oe=0, busy=0. A start 2 cycles later runs a full correct transaction.
- nbytes=0 -> address-only probe, done after 4*QDIV*11 cycles. Also: start pulsed while busy is ignored, and nbytes=7 with MAX_BYTES=4 sends exactly 4 bytes.
